// File: rtl/sh_deser.sv
// sh_deser -- serial-to-parallel deserializer with a one-word output register.
//
// Bits arrive LSB first on sh_in and are captured only on edges where the
// strobe sh is high. After W strobes the assembled word is offered on q with
// vld. A word that completes while the previous one is still unconsumed
// (vld=1, rdy=0) is dropped and the sticky ovr flag is raised. The serial side
// never stalls.
//
// Ports
//   clk    in   single clock, all state on posedge
//   rst    in   synchronous active-high reset
//   sh_in  in   serial data bit (LSB of each word first)
//   sh     in   bit strobe
//   rdy    in   consumer ready for q
//   clr    in   clears sticky ovr
//   q      out  last completed word (registered)
//   vld    out  q holds an unconsumed word
//   busy   out  partial word in progress (cnt != 0)
//   cnt    out  bits captured in the current word
//   ovr    out  sticky overrun flag
module sh_deser #(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sh_in,
  input  logic                   sh,
  input  logic                   rdy,
  input  logic                   clr,
  output logic [W-1:0]           q,
  output logic                   vld,
  output logic                   busy,
  output logic [$clog2(W)-1:0]   cnt,
  output logic                   ovr
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CMAX = CW'(W - 1);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d;
  logic [0:0]    st_q, st_d;
  logic          ovr_q, ovr_d;

  logic          done;
  logic [W-1:0]  word;
  logic          overrun;

  // The word is taken from the shift input directly so it is ready on the
  // same edge as the last strobe, not one edge later.
  assign word = {sh_in, sr_q[W-1:1]};
  assign done = sh && (cnt_q == CMAX);

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    st_d    = st_q;
    overrun = 1'b0;

    if (sh) begin
      sr_d  = word;
      // Explicit wrap: W need not be a power of two.
      cnt_d = (cnt_q == CMAX) ? '0 : cnt_q + 1'b1;
    end

    case (st_q)
      EMPTY: begin
        if (done) begin
          st_d = FULL;
          q_d  = word;
        end
      end
      default: begin
        if (done) begin
          // Consumer draining this edge frees the slot for the new word.
          if (rdy) q_d = word;
          else     overrun = 1'b1;
        end else if (rdy) begin
          st_d = EMPTY;
        end
      end
    endcase

    // Set wins over clear.
    if (overrun)  ovr_d = 1'b1;
    else if (clr) ovr_d = 1'b0;
    else          ovr_d = ovr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      st_q  <= EMPTY;
      ovr_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
      st_q  <= st_d;
      ovr_q <= ovr_d;
    end
  end

  assign q    = q_q;
  assign vld  = (st_q == FULL);
  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_sh_deser.sv
// Self-checking bench for sh_deser (W=8). Expected words are queued when the
// stimulus that should produce them is driven and popped when q is checked.
module tb_sh_deser;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, sh_in, sh, rdy, clr;
  logic [W-1:0] q;
  logic         vld, busy, ovr;
  logic [2:0]   cnt;

  int checks = 0;
  int errs   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_q;

  sh_deser #(.W(W)) dut (
    .clk(clk), .rst(rst), .sh_in(sh_in), .sh(sh), .rdy(rdy), .clr(clr),
    .q(q), .vld(vld), .busy(busy), .cnt(cnt), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs then change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift bits lo..hi of w. toggle inserts an sh=0 cycle between strobes.
  // lrdy/lclr are asserted only on the edge of bit hi.
  task automatic send_bits(input logic [W-1:0] w, input int lo, input int hi,
                           input bit toggle, input bit lrdy, input bit lclr);
    for (int i = lo; i <= hi; i++) begin
      sh    = 1'b1;
      sh_in = w[i];
      rdy   = (i == hi) ? lrdy : 1'b0;
      clr   = (i == hi) ? lclr : 1'b0;
      tick();
      sh  = 1'b0;
      rdy = 1'b0;
      clr = 1'b0;
      if (toggle && i != hi) begin
        sh_in = ~sh_in;
        tick();
      end
    end
  endtask

  task automatic pop_q(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL %s: scoreboard empty, got q %0h", tag, q);
    end else begin
      last_q = exp_q.pop_front();
      chk(tag, q, last_q);
    end
  endtask

  initial begin
    rst = 1'b1; sh = 1'b1; sh_in = 1'b1; rdy = 1'b1; clr = 1'b1;
    tick();
    chk("rst_q", q, 0); chk("rst_vld", vld, 0); chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0); chk("rst_ovr", ovr, 0);
    rst = 1'b0; sh = 1'b0; sh_in = 1'b0; rdy = 1'b0; clr = 1'b0;
    tick();

    // A5 back-to-back, rdy low
    send_bits(8'hA5, 0, 2, 0, 0, 0);
    chk("a5_cnt3", cnt, 3); chk("a5_busy", busy, 1); chk("a5_vld0", vld, 0);
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 3, 7, 0, 0, 0);
    pop_q("a5_q");
    chk("a5_vld", vld, 1); chk("a5_cnt", cnt, 0);
    chk("a5_busy0", busy, 0); chk("a5_ovr", ovr, 0);

    // Overrun: FF dropped
    send_bits(8'hFF, 0, 7, 0, 0, 0);
    chk("ovr_q", q, last_q); chk("ovr_vld", vld, 1); chk("ovr_set", ovr, 1);
    tick();
    chk("ovr_sticky", ovr, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ovr_clr", ovr, 0); chk("ovr_clr_q", q, last_q);

    // Simultaneous consume and completion
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 0, 7, 0, 1, 0);
    pop_q("5a_q");
    chk("5a_vld", vld, 1); chk("5a_ovr", ovr, 0);

    // Consume, then 3C with toggled strobe
    rdy = 1'b1; tick(); rdy = 1'b0;
    chk("5a_cons_vld", vld, 0); chk("5a_cons_q", q, last_q);
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 0, 7, 1, 0, 0);
    pop_q("3c_q");
    chk("3c_vld", vld, 1);
    rdy = 1'b1; tick(); rdy = 1'b0;
    chk("3c_cons_vld", vld, 0); chk("3c_cons_q", q, last_q);
    rdy = 1'b1; tick(); rdy = 1'b0;
    chk("empty_rdy_vld", vld, 0); chk("empty_rdy_q", q, last_q);

    // Reset mid-word
    send_bits(8'hC3, 0, 2, 0, 0, 0);
    chk("mid_cnt", cnt, 3); chk("mid_busy", busy, 1);
    rst = 1'b1; sh = 1'b1; sh_in = 1'b1; rdy = 1'b1; tick();
    rst = 1'b0; sh = 1'b0; rdy = 1'b0;
    chk("mid_rst_cnt", cnt, 0); chk("mid_rst_vld", vld, 0); chk("mid_rst_q", q, 0);
    exp_q.push_back(8'h81);
    send_bits(8'h81, 0, 7, 0, 0, 0);
    pop_q("81_q");
    chk("81_vld", vld, 1);

    // Idle strobe with toggling data mid-word
    send_bits(8'h6B, 0, 2, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      sh_in = i[0];
      tick();
    end
    chk("idle_cnt", cnt, 3); chk("idle_q", q, last_q); chk("idle_vld", vld, 1);
    exp_q.push_back(8'h6B);
    send_bits(8'h6B, 3, 7, 0, 1, 0);
    pop_q("6b_q");

    // Clear and new overrun on the same edge: set wins
    send_bits(8'h12, 0, 7, 0, 0, 1);
    chk("clrset_ovr", ovr, 1); chk("clrset_q", q, last_q);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clrset_clr", ovr, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
